// File: rtl/alu_mdu_pkg.sv
// Shared opcode encodings and FSM state type for the execute-stage ALU/MDU.
// The divider state only exists when ALU_MDU_DIV_EN is defined.
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluCmp  = 4'd2,
    AluUcmp = 4'd3,
    AluAnd  = 4'd4,
    AluOr   = 4'd5,
    AluXor  = 4'd6,
    AluSll  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MopMul    = 3'd0,
    MopMulh   = 3'd1,
    MopMulhsu = 3'd2,
    MopMulhu  = 3'd3,
    MopDiv    = 3'd4,
    MopDivu   = 3'd5,
    MopRem    = 3'd6,
    MopRemu   = 3'd7
  } mop_e;

  // opcode bit that selects the M extension
  localparam int unsigned MopBit = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
`ifdef ALU_MDU_DIV_EN
    StDiv,
`endif
    StDone
  } state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between the execute stage and alu_mdu.
interface alu_mdu_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      opcode;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd;
  logic            zero;
  logic            busy;

  modport slave (
    input  in_valid, opcode, rs1, rs2, out_ready,
    output in_ready, out_valid, rd, zero, busy
  );

  modport master (
    output in_valid, opcode, rs1, rs2, out_ready,
    input  in_ready, out_valid, rd, zero, busy
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative multiply (shift-add) and restoring divide, one bit per cycle on magnitudes.
// The divider datapath is only built when ALU_MDU_DIV_EN is defined.
module alu_mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int unsigned CW = $clog2(XLEN);

  logic              run_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   dsor_q;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic              sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     sum;
`ifdef ALU_MDU_DIV_EN
  logic [XLEN:0]     rem_sh, diff;
`endif

  always_comb begin
    sgn1 = funct3 inside {MopMulh, MopMulhsu, MopDiv, MopRem};
    sgn2 = funct3 inside {MopMulh, MopDiv, MopRem};
    neg1 = sgn1 & rs1[XLEN-1];
    neg2 = sgn2 & rs2[XLEN-1];
    mag1 = neg1 ? -rs1 : rs1;
    mag2 = neg2 ? -rs2 : rs2;
  end

  // acc_q holds {partial product | remainder, multiplier | dividend->quotient}
  always_comb begin
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dsor_q} : '0);
    acc_d = {sum, acc_q[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
    rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dsor_q};
    if (f3_q[2]) begin
      if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
`endif
  end

  // Result is taken from the final step's next value so rd can be written on the last edge.
  always_comb begin
    prod   = neg_q ? -acc_d : acc_d;
    result = (f3_q == MopMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
    if (f3_q[2]) begin
      if (f3_q[1]) result = neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
      else         result = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    end
`endif
  end

  assign done = run_q && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      dsor_q <= '0;
      acc_q  <= '0;
    end else if (start) begin
      run_q  <= 1'b1;
      cnt_q  <= CW'(XLEN - 1);
      f3_q   <= funct3;
      neg_q  <= (funct3 == MopRem) ? neg1 : (neg1 ^ neg2);
      dsor_q <= mag2;
      acc_q  <= {{XLEN{1'b0}}, mag1};
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative RV32M/RV64M multiply/divide behind valid/ready handshakes.
// Define ALU_MDU_DIV_EN to build the divider; otherwise funct3 4-7 return 0 after one cycle.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  alu_mdu_if.slave   bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q;
  logic [XLEN-1:0] rd_q;
  logic            out_valid_q;
  logic            busy_q;

  logic            accept, is_m, m_iter, iter_start, iter_done;
  logic [2:0]      f3;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] base_res, imm_res, iter_result;

  assign bus.in_ready  = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign is_m          = bus.opcode[MopBit];
  assign f3            = bus.opcode[2:0];
  assign sh            = bus.rs2[SHW-1:0];
  assign bus.rd        = rd_q;
  assign bus.out_valid = out_valid_q;
  assign bus.zero      = (rd_q == '0);
  assign bus.busy      = busy_q;

  always_comb begin
    base_res = '0;
    case (bus.opcode[3:0])
      AluAdd:  base_res = bus.rs1 + bus.rs2;
      AluSub:  base_res = bus.rs1 - bus.rs2;
      AluCmp:  base_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1) < $signed(bus.rs2)};
      AluUcmp: base_res = {{(XLEN-1){1'b0}}, bus.rs1 < bus.rs2};
      AluAnd:  base_res = bus.rs1 & bus.rs2;
      AluOr:   base_res = bus.rs1 | bus.rs2;
      AluXor:  base_res = bus.rs1 ^ bus.rs2;
      AluSll:  base_res = bus.rs1 << sh;
      AluSrl:  base_res = bus.rs1 >> sh;
      AluSra:  base_res = $signed(bus.rs1) >>> sh;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MDU_DIV_EN
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  // Divide-by-zero and signed overflow resolve in one cycle without iterating.
  always_comb begin
    div_zero = (bus.rs2 == '0);
    div_ovf  = !f3[0] && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
    fast     = div_zero || div_ovf;
    if (f3[1]) fast_res = div_zero ? bus.rs1 : '0;
    else       fast_res = div_zero ? '1 : bus.rs1;
  end
`endif

  always_comb begin
    imm_res = base_res;
    m_iter  = 1'b0;
    if (is_m) begin
      imm_res = '0;
      m_iter  = !f3[2];
`ifdef ALU_MDU_DIV_EN
      if (f3[2]) begin
        imm_res = fast_res;
        m_iter  = !fast;
      end
`endif
    end
  end

  assign iter_start = accept && m_iter;

  alu_mdu_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .funct3 (f3),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iter_start) begin
`ifdef ALU_MDU_DIV_EN
            state_q <= f3[2] ? StDiv : StMul;
`else
            state_q <= StMul;
`endif
            busy_q  <= 1'b1;
          end else if (accept) begin
            rd_q        <= imm_res;
            out_valid_q <= 1'b1;
          end
        end
`ifdef ALU_MDU_DIV_EN
        StMul, StDiv: begin
`else
        StMul: begin
`endif
          if (iter_done) begin
            rd_q        <= iter_result;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
